// File: rtl/pipe_trace_pkg.sv
// rtl/pipe_trace_pkg.sv - state encoding and width helper for the pipeline trace buffer
package pipe_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - DEPTH x (CH*W) sample store, one write port, registered read with channel select
module trace_ram
    import pipe_trace_pkg::*;
#(
    parameter  int W     = 32,
    parameter  int CH    = 4,
    parameter  int DEPTH = 16,
    localparam int AW    = clog2(DEPTH),
    localparam int CHW   = (CH > 1) ? clog2(CH) : 1
) (
    input  logic              clk_i,
    input  logic              clrn_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [CH*W-1:0]   wr_data_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    input  logic [CHW-1:0]    rd_ch_i,
    output logic [W-1:0]      rd_data_o
);

    logic [CH*W-1:0] mem_q [DEPTH];
    logic [CH*W-1:0] row_q;
    logic [CHW-1:0]  ch_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    // Only the output row is reset so the read data reads zero while held in reset.
    always_ff @(posedge clk_i or negedge clrn_i) begin
        if (!clrn_i) begin
            row_q <= '0;
            ch_q  <= '0;
        end else if (rd_en_i) begin
            row_q <= mem_q[rd_addr_i];
            ch_q  <= rd_ch_i;
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < CH; k++) begin
            if (ch_q == CHW'(k)) rd_data_o = row_q[k*W +: W];
        end
    end

endmodule

// File: rtl/pipe_trace_buffer.sv
// rtl/pipe_trace_buffer.sv - triggered circular capture of pipeline probe channels with oldest-first readout
module pipe_trace_buffer
    import pipe_trace_pkg::*;
#(
    parameter  int W     = 32,
    parameter  int CH    = 4,
    parameter  int DEPTH = 16,
    parameter  int POST  = 8,
    localparam int AW    = clog2(DEPTH),
    localparam int CNTW  = AW + 1,
    localparam int CHW   = (CH > 1) ? clog2(CH) : 1
) (
    input  logic              clk_i,
    input  logic              clrn_i,
    input  logic [CH*W-1:0]   probe_i,
    input  logic              probe_vld_i,
    input  logic              arm_i,
    input  logic              trig_i,
    input  logic              rd_req_i,
    input  logic [CHW-1:0]    rd_ch_i,
    output logic [W-1:0]      rd_data_o,
    output logic              rd_vld_o,
    output logic              rd_last_o,
    output logic [1:0]        state_o,
    output logic [CNTW-1:0]   count_o
);

    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] POST_C  = CNTW'(POST);

    trace_state_e    state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] fill_q, fill_d, post_q, post_d, left_q, left_d;
    logic            rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
    logic            wr_en, rd_en;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        fill_d    = fill_q;
        post_d    = post_q;
        left_d    = left_q;
        rd_vld_d  = 1'b0;
        rd_last_d = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm_i) begin
                    wr_ptr_d = '0;
                    fill_d   = '0;
                    post_d   = '0;
                    state_d  = ST_ARMED;
                end
            end
            ST_ARMED, ST_POST: begin
                wr_en = probe_vld_i;
                if (probe_vld_i) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (fill_q != DEPTH_C) fill_d = fill_q + CNTW'(1);
                end
                // A qualified sample on the trigger cycle is already the first post sample.
                if (state_q == ST_ARMED) begin
                    if (trig_i) begin
                        post_d  = POST_C - CNTW'(probe_vld_i);
                        state_d = (post_d == '0) ? ST_DONE : ST_POST;
                    end
                end else if (probe_vld_i) begin
                    post_d = post_q - CNTW'(1);
                    if (post_q == CNTW'(1)) state_d = ST_DONE;
                end
                if (state_d == ST_DONE) begin
                    rd_ptr_d = wr_ptr_d - fill_d[AW-1:0];
                    left_d   = fill_d;
                end
            end
            ST_DONE: begin
                if (arm_i) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    fill_d   = '0;
                    post_d   = '0;
                    left_d   = '0;
                    state_d  = ST_ARMED;
                end else if (rd_req_i) begin
                    rd_en    = 1'b1;
                    rd_vld_d = 1'b1;
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    left_d   = left_q - CNTW'(1);
                    if (left_q == CNTW'(1)) begin
                        rd_last_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge clrn_i) begin
        if (!clrn_i) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            post_q    <= '0;
            left_q    <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            post_q    <= post_d;
            left_q    <= left_d;
            rd_vld_q  <= rd_vld_d;
            rd_last_q <= rd_last_d;
        end
    end

    trace_ram #(
        .W     (W),
        .CH    (CH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i     (clk_i),
        .clrn_i    (clrn_i),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (probe_i),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q),
        .rd_ch_i   (rd_ch_i),
        .rd_data_o (rd_data_o)
    );

    assign rd_vld_o  = rd_vld_q;
    assign rd_last_o = rd_last_q;
    assign state_o   = state_q;
    assign count_o   = fill_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb/tb_pipe_trace_buffer.sv - randomized self-checking bench for pipe_trace_buffer against a history-queue model
module tb_pipe_trace_buffer;

    localparam int W = 32, CH = 4, DEPTH = 16, POST = 8, CNTW = $clog2(DEPTH) + 1;
    typedef logic [CH*W-1:0] row_t;

    logic clk = 1'b0, clrn = 1'b0, vld = 1'b0, arm = 1'b0, trig = 1'b0, rd_req = 1'b0;
    logic [CH*W-1:0] probe = '0;
    logic [1:0]      rd_ch = '0;
    logic [W-1:0]    rd_data;
    logic            rd_vld, rd_last;
    logic [1:0]      state;
    logic [CNTW-1:0] count;
    logic [0:0]      rd_ch1 = '0;
    logic [W-1:0]    rd_data1;
    logic            rd_vld1, rd_last1;
    logic [1:0]      state1;
    logic [2:0]      count1;

    pipe_trace_buffer #(.W(W), .CH(CH), .DEPTH(DEPTH), .POST(POST)) u_dut (
        .clk_i(clk), .clrn_i(clrn), .probe_i(probe), .probe_vld_i(vld), .arm_i(arm),
        .trig_i(trig), .rd_req_i(rd_req), .rd_ch_i(rd_ch), .rd_data_o(rd_data),
        .rd_vld_o(rd_vld), .rd_last_o(rd_last), .state_o(state), .count_o(count)
    );

    pipe_trace_buffer #(.W(W), .CH(1), .DEPTH(4), .POST(1)) u_dut1 (
        .clk_i(clk), .clrn_i(clrn), .probe_i(probe[W-1:0]), .probe_vld_i(vld), .arm_i(arm),
        .trig_i(trig), .rd_req_i(rd_req), .rd_ch_i(rd_ch1), .rd_data_o(rd_data1),
        .rd_vld_o(rd_vld1), .rd_last_o(rd_last1), .state_o(state1), .count_o(count1)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    row_t hist[$];
    int m_state = 0, m_post_left = 0, m_cnt = 0, m_reads = 0;
    logic e_vld = 1'b0, e_last = 1'b0;
    logic [W-1:0] e_data = '0;

    function automatic int ecount();
        return (hist.size() < DEPTH) ? hist.size() : DEPTH;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int k = 0; k < CH; k++) r[k*W +: W] = $urandom();
        return r;
    endfunction

    // Drive one cycle and advance the reference model; outputs are then sampled 1 ns after the edge.
    task automatic step(input logic a, input logic t, input logic v, input logic r,
                        input logic [1:0] c, input row_t p);
        row_t rr;
        arm = a; trig = t; vld = v; rd_req = r; rd_ch = c; probe = p;
        @(posedge clk);
        e_vld = 1'b0; e_last = 1'b0;
        case (m_state)
            0: if (a) begin hist.delete(); m_state = 1; end
            1, 2: begin
                if (v) hist.push_back(p);
                if (m_state == 1) begin
                    if (t) begin m_post_left = POST - int'(v); m_state = 2; end
                end else if (v) m_post_left--;
                if (m_state == 2 && m_post_left == 0) begin m_state = 3; m_cnt = ecount(); m_reads = 0; end
            end
            default: begin
                if (a) begin hist.delete(); m_state = 1; end
                else if (r) begin
                    rr = hist[hist.size() - m_cnt + m_reads];
                    e_data = rr[int'(c)*W +: W];
                    e_vld = 1'b1;
                    m_reads++;
                    if (m_reads == m_cnt) begin e_last = 1'b1; m_state = 0; end
                end
            end
        endcase
        #1;
    endtask

    task automatic test_reset();
        clrn = 1'b0; arm = 0; trig = 0; vld = 0; rd_req = 0; probe = '0; rd_ch = '0;
        hist.delete(); m_state = 0; e_vld = 0; e_last = 0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (state !== 2'd0 || count !== '0 || rd_vld !== 1'b0 || rd_last !== 1'b0 || rd_data !== '0) begin
            miscompares++;
            $display("FAIL reset st=%0d cnt=%0d vld=%b last=%b data=%h (want all 0)", state, count, rd_vld, rd_last, rd_data);
        end
        clrn = 1'b1;
        step(0, 0, 0, 0, 0, '0);
        vectors++;
        if (state !== 2'd0 || count !== '0 || rd_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle st=%0d cnt=%0d vld=%b (want 0 0 0)", state, count, rd_vld);
        end
    endtask

    task automatic test_basic();
        row_t r;
        test_reset();
        step(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 28; i++) begin
            r = rand_row(); r[W-1:0] = 32'(4 * i);
            step(0, i == 20, 1, 0, 0, r);
            vectors++;
            if (state !== 2'(m_state) || count !== CNTW'(ecount())) begin
                miscompares++;
                $display("FAIL basic_cap i=%0d st=%0d/%0d cnt=%0d/%0d (got/want)", i, state, m_state, count, ecount());
            end
        end
        vectors++;
        if (state !== 2'd3 || count !== CNTW'(16)) begin
            miscompares++;
            $display("FAIL basic_done st=%0d cnt=%0d (want 3 16)", state, count);
        end
        for (int k = 0; k < 16; k++) begin
            step(0, 0, 0, 1, 0, '0);
            vectors++;
            if (rd_vld !== 1'b1 || rd_data !== 32'(32'h30 + 4 * k) || rd_last !== (k == 15) || rd_data !== e_data) begin
                miscompares++;
                $display("FAIL basic_pc k=%0d vld=%b data=%h last=%b want data=%h last=%b", k, rd_vld, rd_data, rd_last, 32'(32'h30 + 4 * k), k == 15);
            end
        end
        vectors++;
        if (state !== 2'd0) begin miscompares++; $display("FAIL basic_idle st=%0d want 0", state); end
    endtask

    task automatic test_short();
        int n_resp = 0;
        test_reset();
        step(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 40 && m_state != 3; i++) step(0, i == 3, 1, 0, 0, rand_row());
        vectors++;
        if (state !== 2'd3 || count !== CNTW'(11)) begin
            miscompares++;
            $display("FAIL short_done st=%0d cnt=%0d (want 3 11)", state, count);
        end
        for (int c = 0; c < 80 && m_state == 3; c++) begin
            step(0, 0, 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_row());
            if (rd_vld) n_resp++;
            vectors++;
            if (state !== 2'(m_state) || rd_vld !== e_vld || rd_last !== e_last || (e_vld && rd_data !== e_data)) begin
                miscompares++;
                $display("FAIL short_rd c=%0d st=%0d/%0d vld=%b/%b last=%b/%b data=%h/%h (got/want)", c, state, m_state, rd_vld, e_vld, rd_last, e_last, rd_data, e_data);
            end
        end
        vectors++;
        if (n_resp != 11 || state !== 2'd0) begin
            miscompares++;
            $display("FAIL short_end responses=%0d st=%0d (want 11 0)", n_resp, state);
        end
    endtask

    task automatic test_stalls();
        row_t r;
        int seq = 0, clocks = 0;
        test_reset();
        step(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 10; i++) begin r = rand_row(); r[W-1:0] = 32'(4 * seq); seq++; step(0, 0, 1, 0, 0, r); end
        for (int j = 0; j < 40 && state !== 2'd3; j++) begin
            r = rand_row();
            if (j % 2 == 0) begin r[W-1:0] = 32'(4 * seq); seq++; end
            step(0, j == 0, (j % 2 == 0), 0, 0, r);
            clocks++;
        end
        vectors++;
        if (state !== 2'd3 || clocks != 15 || count !== CNTW'(16)) begin
            miscompares++;
            $display("FAIL stalls_done st=%0d clocks=%0d cnt=%0d (want 3 15 16)", state, clocks, count);
        end
        for (int k = 0; k < 16; k++) begin
            step(0, 0, 0, 1, 0, '0);
            vectors++;
            if (rd_vld !== 1'b1 || rd_data !== 32'(4 * (2 + k)) || rd_data !== e_data || rd_last !== e_last) begin
                miscompares++;
                $display("FAIL stalls_rd k=%0d vld=%b data=%h last=%b want data=%h last=%b", k, rd_vld, rd_data, rd_last, 32'(4 * (2 + k)), e_last);
            end
        end
    endtask

    task automatic test_channels();
        row_t r;
        test_reset();
        step(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 20; i++) begin
            r = rand_row(); r[3*W +: W] = 32'hA5A5_0000 + 32'(i);
            step(0, i == 12, 1, 0, 0, r);
        end
        for (int k = 0; k < 16; k++) begin
            step(0, 0, 0, 1, 2'(k % 4), '0);
            vectors++;
            if (rd_vld !== 1'b1 || rd_data !== e_data || rd_last !== e_last ||
                (k % 4 == 3 && rd_data !== 32'hA5A5_0000 + 32'(4 + k))) begin
                miscompares++;
                $display("FAIL chan k=%0d ch=%0d vld=%b data=%h last=%b want data=%h last=%b", k, k % 4, rd_vld, rd_data, rd_last, e_data, e_last);
            end
        end
    endtask

    task automatic test_ignored();
        test_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 1, 0, rand_row());
            vectors++;
            if (state !== 2'd0 || rd_vld !== 1'b0 || count !== '0) begin
                miscompares++;
                $display("FAIL idle_trig st=%0d vld=%b cnt=%0d (want 0 0 0)", state, rd_vld, count);
            end
        end
        step(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 1, 0, rand_row());
            vectors++;
            if (state !== 2'd1 || rd_vld !== 1'b0 || count !== CNTW'(i + 1)) begin
                miscompares++;
                $display("FAIL armed_rd st=%0d vld=%b cnt=%0d (want 1 0 %0d)", state, rd_vld, count, i + 1);
            end
        end
    endtask

    task automatic test_rearm();
        test_reset();
        step(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 40 && m_state != 3; i++) step(0, i == 5, 1, 0, 0, rand_row());
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 1, '0);
        step(1, 0, 0, 1, 1, '0);
        vectors++;
        if (state !== 2'd1 || rd_vld !== 1'b0 || count !== '0) begin
            miscompares++;
            $display("FAIL rearm st=%0d vld=%b cnt=%0d (want 1 0 0)", state, rd_vld, count);
        end
        for (int i = 0; i < 40 && m_state != 3; i++) step(0, i == 5, 1, 0, 0, rand_row());
        vectors++;
        if (state !== 2'd3 || count !== CNTW'(13)) begin
            miscompares++;
            $display("FAIL rearm_done st=%0d cnt=%0d (want 3 13)", state, count);
        end
        for (int k = 0; k < 13; k++) begin
            step(0, 0, 0, 1, 2'($urandom_range(0, 3)), '0);
            vectors++;
            if (rd_vld !== 1'b1 || rd_data !== e_data || rd_last !== e_last || state !== 2'(m_state)) begin
                miscompares++;
                $display("FAIL rearm_rd k=%0d vld=%b data=%h/%h last=%b/%b st=%0d/%0d (got/want)", k, rd_vld, rd_data, e_data, rd_last, e_last, state, m_state);
            end
        end
    endtask

    task automatic test_reset_mid();
        test_reset();
        step(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 40 && m_state != 3; i++) step(0, i == 9, 1, 0, 0, rand_row());
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 2, '0);
        vectors++;
        if (rd_vld !== 1'b1 || rd_data !== e_data) begin
            miscompares++;
            $display("FAIL mid_rd vld=%b data=%h want 1 %h", rd_vld, rd_data, e_data);
        end
        #2 clrn = 1'b0;
        #1;
        vectors++;
        if (state !== 2'd0 || count !== '0 || rd_vld !== 1'b0 || rd_last !== 1'b0 || rd_data !== '0) begin
            miscompares++;
            $display("FAIL mid_reset st=%0d cnt=%0d vld=%b last=%b data=%h (want all 0)", state, count, rd_vld, rd_last, rd_data);
        end
        hist.delete(); m_state = 0;
        @(negedge clk);
        clrn = 1'b1;
        step(0, 0, 0, 1, 0, '0);
        vectors++;
        if (state !== 2'd0 || rd_vld !== 1'b0 || count !== '0) begin
            miscompares++;
            $display("FAIL mid_after st=%0d vld=%b cnt=%0d (want 0 0 0)", state, rd_vld, count);
        end
    endtask

    task automatic test_random();
        test_reset();
        for (int c = 0; c < 1500; c++) begin
            step(($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < 60), 2'($urandom_range(0, 3)), rand_row());
            vectors++;
            if (state !== 2'(m_state) || count !== CNTW'(ecount()) || rd_vld !== e_vld || rd_last !== e_last ||
                (e_vld && rd_data !== e_data)) begin
                miscompares++;
                $display("FAIL random c=%0d st=%0d/%0d cnt=%0d/%0d vld=%b/%b last=%b/%b data=%h/%h (got/want)",
                         c, state, m_state, count, ecount(), rd_vld, e_vld, rd_last, e_last, rd_data, e_data);
            end
        end
    endtask

    task automatic test_post1();
        row_t rows[6];
        test_reset();
        step(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 6; i++) begin
            rows[i] = rand_row();
            step(0, i == 5, 1, 0, 0, rows[i]);
            vectors++;
            if (state1 !== ((i == 5) ? 2'd3 : 2'd1) || count1 !== 3'((i < 3) ? i + 1 : 4)) begin
                miscompares++;
                $display("FAIL post1_cap i=%0d st=%0d cnt=%0d", i, state1, count1);
            end
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 1, 0, '0);
            vectors++;
            if (rd_vld1 !== 1'b1 || rd_data1 !== rows[2 + k][W-1:0] || rd_last1 !== (k == 3)) begin
                miscompares++;
                $display("FAIL post1_rd k=%0d vld=%b data=%h last=%b want data=%h last=%b", k, rd_vld1, rd_data1, rd_last1, rows[2 + k][W-1:0], k == 3);
            end
        end
        vectors++;
        if (state1 !== 2'd0) begin miscompares++; $display("FAIL post1_idle st=%0d want 0", state1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_stalls();
        test_channels();
        test_ignored();
        test_rearm();
        test_reset_mid();
        test_post1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_trace_buffer.md
# pipe_trace_buffer

Synthesizable capture buffer for the pipelined CPU. It samples CH probe channels every qualified clock into a circular memory of DEPTH entries. Typical channels are the IF-stage PC, the IF instruction, the E/M ALU results and the WB register data. On a trigger it captures a programmable number of post-trigger samples, then freezes for oldest-first readout. This replaces waveform-only inspection of the pipeline taps with on-chip history that the board and the bench can both read.

## Interface
- W, 32, width of one probe channel
- CH, 4, number of probe channels (≥1)
- DEPTH, 16, entries in the ring; power of 2, ≥2
- POST, 8, samples kept from the trigger onward; 1 ≤ POST ≤ DEPTH
- Clk  in  1  single clock; all logic is rising-edge
- Clrn  in  1  asynchronous active-low reset
- Probe  in  CH*W  probe bus; channel k occupies bits [k*W +: W]
- Probe_vld  in  1  sample qualifier; low means a pipeline stall or bubble, nothing is stored
- Arm  in  1  start a capture (level, sampled each cycle)
- Trig  in  1  trigger event
- Rd_req  in  1  read one entry (DONE only)
- Rd_ch  in  clog2(CH) (min 1)  channel to return, sampled together with Rd_req
- Rd_data  out  W  read data, registered
- Rd_vld  out  1  Rd_data is valid this cycle
- Rd_last  out  1  qualifies the final entry of a readout, with Rd_vld
- State  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
- Count  out  clog2(DEPTH)+1  number of valid stored entries

## Operation
- **IDLE:** nothing is written. Arm=1 clears the fill counter and write pointer and moves to ARMED.
- **ARMED:** each Probe_vld=1 cycle writes the whole Probe bus at wr_ptr. wr_ptr then increments mod DEPTH. The fill counter increments, saturating at DEPTH. Trig=1 moves to POST and loads post_cnt=POST.
- **Trigger cycle:** if Probe_vld=1 in the same cycle as Trig, that sample is stored and counts as the first post sample, so post_cnt=POST-1 next cycle. If that leaves post_cnt at 0 (POST=1), the state moves to DONE immediately.
- **POST:** each Probe_vld=1 cycle stores a sample and decrements post_cnt. The state moves to DONE on the cycle that stores the final post sample. Further Trig pulses are ignored.
- **DONE:** writes stop. Count = fill counter. rd_ptr = (wr_ptr − Count) mod DEPTH, which is the oldest entry.
  - Each Rd_req reads entry rd_ptr, channel Rd_ch, and advances rd_ptr.
  - When Count reads have been issued, the state returns to IDLE. The final read's response still completes, with Rd_last=1.
- **Pre-trigger history:** min(fill − post_stored, DEPTH − POST) entries. Older samples are overwritten.
- **Arm outside IDLE:**
  - In DONE, Arm=1 abandons the readout, has priority over Rd_req, and re-arms: it clears the counters and goes to ARMED.
  - In ARMED or POST, Arm is ignored.
- **Ignored inputs:**
  - Trig in IDLE or DONE.
  - Rd_req outside DONE: no Rd_vld results.
- **Count:** reads 0 in IDLE after reset. During ARMED and POST it tracks the fill counter. It holds during readout.
- **Memory contents:** not reset. No output depends on unwritten entries.

## Timing
- **Write:** a sample is visible to readout one cycle after its Probe_vld cycle.
- **Read latency:** Rd_req at edge n gives Rd_data/Rd_vld (and Rd_last) valid after edge n+1, for one cycle.
- **Back-to-back reads:** Rd_req may stay high every cycle for full throughput.
- **Trigger to DONE:** DONE is entered on the edge that stores the last post sample, at the earliest POST−1 cycles after the trigger edge. The first Rd_req is accepted the cycle after DONE is observed.
- **Reset:**
  - While Clrn=0: State=IDLE, Count=0, Rd_data=0, Rd_vld=0, Rd_last=0, all pointers and counters 0.
  - Reset mid-capture or mid-readout aborts immediately. An in-flight read response is dropped.
- **Wrap-around:** wr_ptr and rd_ptr wrap DEPTH−1→0 with no bubble.

## Structure
- **Package pipe_trace_pkg:** state encoding constants (ST_IDLE … ST_DONE) and the clog2 helper used for pointer and counter widths.
- **Sub-module trace_ram:**
  - DEPTH × (CH*W), one write port, one registered read port.
  - Rd_ch is registered alongside the read address, and the channel select is applied to the RAM output.
- **Top level:** holds the FSM, pointers, fill and post counters, and read-response registers.

## Test plan
- **Basic:** DEPTH=16, POST=8, Probe ch0=PC 0x00,0x04,…; Arm, Trig at sample 20 → DONE after 8 post samples, Count=16. Readout returns PCs 0x30…0x6C oldest first; Rd_last on the 16th response.
- **Short history:** Trig at sample 3 after Arm → Count=11 (3 pre + 8 post), 11 reads, Rd_last on the 11th, then State=IDLE.
- **Stalls:** Probe_vld toggling 1,0,1,0 during POST → only qualified samples are stored. DONE is reached after 8 valid cycles, about 16 clocks, with no duplicate PCs.
- **Simultaneous and ignored events:**
  - POST=1, Trig with Probe_vld=1 → DONE next cycle, and the final entry read is the trigger sample.
  - Trig in IDLE → State stays 0.
  - Rd_req in ARMED → no Rd_vld.
- **Re-arm and reset:**
  - Arm and Rd_req together in DONE → ARMED, no Rd_vld, Count=0.
  - Clrn pulsed low mid-readout → all outputs 0 and State=IDLE, asynchronously.
- **Channels:** CH=4, ch3=W_RegDin pattern 0xA5A5_0000+i; Rd_ch cycling 0..3 over consecutive reads → each response matches the selected channel of the entry read, with 1-cycle latency.
